mttkrp_output_merger: RTL and testbench
=======================================

Name: mttkrp_output_merger

Overview:
- Downstream of the per-PE MTTKRP compute units.
- During each unit's drain phase, it collects the partial output-factor rows from NUM_PE units, each streaming rows 0..NUM_ROWS-1 in order.
- It adds row k from all units element-wise in a pipelined adder tree.
- It emits one merged row per index, tagged with the row address, on a valid/ready stream to the result-writeback stage.

Parameters:
- NUM_PE, 4, number of upstream compute units merged (1..16).
- RANK, 16, elements per factor row.
- DATA_WIDTH, 32, bits per element (unsigned, modulo arithmetic).
- NUM_ROWS, 1024, rows per shard drain.
- ROW_ADDR_WIDTH, 10, $clog2(NUM_ROWS).
- FIFO_DEPTH, 4, per-PE input FIFO entries (power of 2, >=4).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- pe_row_en  in  NUM_PE  per-PE row strobe; pe_row[p] is captured when bit p is high.
- pe_row  in  NUM_PE x RANK x DATA_WIDTH  partial rows, packed [NUM_PE-1:0][RANK-1:0][DATA_WIDTH-1:0].
- pe_ready  out  NUM_PE  per-PE ready_to_receive.
- out_valid  out  1  merged row valid.
- out_ready  in  1  downstream accept.
- out_row  out  RANK x DATA_WIDTH  merged row.
- out_addr  out  ROW_ADDR_WIDTH  row index of out_row.
- out_last  out  1  high with the beat whose out_addr = NUM_ROWS-1.
- shard_done  out  1  one-cycle pulse after the last beat handshakes.

Behaviour:
- Reset (rst=0 at a clock edge), any time including mid-drain:
  - All FIFOs flush; row counter = 0; tree pipeline valids cleared.
  - Outputs: out_valid=0, out_last=0, shard_done=0, out_addr=0, out_row=0, pe_ready=0.
- Input FIFOs:
  - One FIFO per PE, width RANK*DATA_WIDTH.
  - pe_ready[p] = (count_p <= FIFO_DEPTH-2), registered. This leaves one slot of slack because an upstream unit may strobe one cycle after seeing ready.
  - A strobe arriving while the FIFO is full is dropped and sets sticky debug flag ovf[p], cleared only by reset. This is a protocol error and must never occur in a legal bench.
  - Simultaneous push and pop on the same FIFO in one cycle is legal; count is unchanged.
- Advance and pop:
  - advance = ~out_valid | out_ready.
  - pop = advance & (all FIFOs non-empty). On pop, all NUM_PE heads are removed in the same cycle.
  - Arrival skew between PEs is absorbed by the FIFOs; rows are never merged across indices.
- Adder tree:
  - L = max(1, clog2(NUM_PE)) register stages. Each stage adds pairs element-wise.
  - Odd operand counts pad with zero.
  - Sums are DATA_WIDTH bits, modulo 2^DATA_WIDTH; carry-out is discarded.
  - Every stage register and its valid bit load only when advance=1 (global stall).
  - The last stage is the output register: out_row, out_valid.
  - Latency: out_valid rises exactly L cycles after the pop cycle when not stalled (NUM_PE=4 -> 2 cycles). Throughput is 1 row/cycle.
  - While out_valid=1 and out_ready=0, out_row, out_addr and out_last hold stable.
- Row counter:
  - Travels with data through the pipeline.
  - Increments on each pop and wraps NUM_ROWS-1 -> 0.
  - out_addr is the counter value captured at pop; out_last = (out_addr == NUM_ROWS-1).
- shard_done:
  - Pulses the cycle after out_valid & out_ready & out_last.
  - The next shard may begin popping in the same cycle as the last handshake; no idle gap is required.
- No state machine beyond the pipeline valids. Mode is implicit from the counter.

Decomposition:
- Package mttkrp_pkg:
  - typedef elem_t = logic [DATA_WIDTH-1:0].
  - typedef row_t = elem_t [RANK-1:0].
  - Function add_row(row_t a, row_t b) for the element-wise modulo add.
  - Defaults for RANK / DATA_WIDTH, shared with the compute units.
- One sub-module: merger_row_fifo.
  - Synchronous FIFO with push, pop, full, empty and count.
  - Parameters: WIDTH, DEPTH.
  - Instantiated NUM_PE times.

Test Plan:
- NUM_PE=4, RANK=16, NUM_ROWS=8, out_ready=1:
  - Stimulus: every PE strobes rows 0..7 back to back; PE p row k element j = 100*k + 10*p + j.
  - Response: out_row[j] for row k = 400*k + 60 + 4j.
  - out_addr 0..7 in order; first out_valid 2 cycles after first pop; out_last on addr 7; shard_done one cycle later.
- Skew:
  - Stimulus: PE3 starts 3 cycles after the others.
  - Response: no pops until PE3's row 0 arrives; other pe_ready drop when count reaches 3 (FIFO_DEPTH=4); sums as above; ovf = 0.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles mid-stream.
  - Response: out_row and out_addr held stable; no rows lost or duplicated; all FIFOs fill and pe_ready falls to 0, then recovers.
- Overflow wrap:
  - Stimulus: all PEs send element 0xC000_0000.
  - Response: out_row element = 0x0000_0000 (4 x 0xC000_0000 mod 2^32); no other side effect.
- Reset mid-drain:
  - Stimulus: rst=0 for 1 cycle after 3 rows are out; then a fresh drain of 8 rows.
  - Response: outputs zero during reset; FIFOs empty; new stream starts at out_addr=0 with correct sums.
- Back-to-back shards:
  - Stimulus: two 8-row drains with no gap.
  - Response: out_addr wraps 7 -> 0; shard_done pulses exactly twice.

Source files
------------

// File: rtl/mttkrp_output_merger_pkg.sv
// Shared element/row types and the element-wise modulo row adder used by the MTTKRP datapath.
// Row defaults match the per-PE compute units so partial rows pass through unchanged.
package mttkrp_pkg;

    localparam int RANK       = 16;
    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] elem_t;
    typedef elem_t [RANK-1:0]      row_t;

    // Carry-out of each element is intentionally dropped (mod 2^DATA_WIDTH).
    function automatic row_t add_row(input row_t a, input row_t b);
        row_t r;
        for (int j = 0; j < RANK; j++) begin
            r[j] = a[j] + b[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/mttkrp_output_merger_if.sv
// Partial-row ingress from the PEs (strobe + registered ready) and merged-row egress (valid/ready).
// Master drives the payload, slave answers with ready; ovf is a sticky debug flag per PE.
interface merger_in_if #(parameter int NUM_PE = 4);
    import mttkrp_pkg::*;

    logic [NUM_PE-1:0] pe_row_en;
    row_t [NUM_PE-1:0] pe_row;
    logic [NUM_PE-1:0] pe_ready;

    modport master (output pe_row_en, output pe_row, input pe_ready);
    modport slave  (input pe_row_en, input pe_row, output pe_ready);
endinterface

interface merger_out_if #(parameter int NUM_PE = 4, parameter int ROW_ADDR_WIDTH = 10);
    import mttkrp_pkg::*;

    logic                      out_valid;
    logic                      out_ready;
    row_t                      out_row;
    logic [ROW_ADDR_WIDTH-1:0] out_addr;
    logic                      out_last;
    logic                      shard_done;
    logic [NUM_PE-1:0]         ovf;

    modport master (output out_valid, input out_ready, output out_row, output out_addr,
                    output out_last, output shard_done, output ovf);
    modport slave  (input out_valid, output out_ready, input out_row, input out_addr,
                    input out_last, input shard_done, input ovf);
endinterface

// File: rtl/mttkrp_output_merger_row_fifo.sv
// Per-PE synchronous row FIFO; zero-latency head (dat_o = oldest entry), push and pop in one cycle.
// A push while full is dropped; the caller owns overflow reporting.
module merger_row_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         dat_i,
    output logic [WIDTH-1:0]         dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dat_o   = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= dat_i;
    end
endmodule

// File: rtl/mttkrp_output_merger.sv
// Merges row k from NUM_PE drain streams through a clog2(NUM_PE)-stage adder tree; latency L cycles from pop.
// Whole tree stalls while out_valid & ~out_ready; PEs are throttled via registered per-FIFO ready.
module mttkrp_output_merger
    import mttkrp_pkg::*;
#(
    parameter int NUM_PE         = 4,
    parameter int NUM_ROWS       = 1024,
    parameter int ROW_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    merger_in_if.slave  pe_if,
    merger_out_if.master res_if
);
    localparam int L  = (NUM_PE <= 2) ? 1 : $clog2(NUM_PE);
    localparam int W  = 1 << L;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]             RDY_MAX   = CW'(FIFO_DEPTH - 2);
    localparam logic [ROW_ADDR_WIDTH-1:0] LAST_ADDR = ROW_ADDR_WIDTH'(NUM_ROWS - 1);

    row_t              head [NUM_PE];
    logic [NUM_PE-1:0] empty, full;
    logic [CW-1:0]     fcount   [NUM_PE];
    logic [CW-1:0]     fcount_d [NUM_PE];
    logic [NUM_PE-1:0] pe_rdy_q, ovf_q;
    logic              advance, pop;

    row_t                      node_q [1:W-1];
    row_t                      kid    [2:2*W-1];
    logic [L:1]                vld_q;
    logic [ROW_ADDR_WIDTH-1:0] addr_q [1:L];
    logic [ROW_ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic                      shard_done_q;

    assign advance = ~res_if.out_valid | res_if.out_ready;
    assign pop     = advance & ~|empty;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        merger_row_fifo #(.WIDTH($bits(row_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (pe_if.pe_row_en[p]),
            .pop_i   (pop),
            .dat_i   (pe_if.pe_row[p]),
            .dat_o   (head[p]),
            .full_o  (full[p]),
            .empty_o (empty[p]),
            .count_o (fcount[p])
        );
    end

    // Ready tracks next-cycle occupancy so a strobe issued one cycle late still fits.
    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            fcount_d[p] = fcount[p];
            case ({pe_if.pe_row_en[p] & ~full[p], pop})
                2'b10:   fcount_d[p] = fcount[p] + CW'(1);
                2'b01:   fcount_d[p] = fcount[p] - CW'(1);
                default: fcount_d[p] = fcount[p];
            endcase
        end
    end

    // Heap-indexed tree: node i sums kids 2i and 2i+1; leaves past NUM_PE are zero padding.
    for (genvar i = 2; i < 2*W; i++) begin : g_kid
        if (i < W) begin : g_node
            assign kid[i] = node_q[i];
        end else if (i - W < NUM_PE) begin : g_leaf
            assign kid[i] = head[i-W];
        end else begin : g_pad
            assign kid[i] = '0;
        end
    end

    assign row_cnt_d = !pop ? row_cnt_q :
                       (row_cnt_q == LAST_ADDR) ? '0 : row_cnt_q + ROW_ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < W; i++) node_q[i] <= '0;
            for (int s = 1; s <= L; s++) addr_q[s] <= '0;
            vld_q        <= '0;
            row_cnt_q    <= '0;
            shard_done_q <= 1'b0;
            pe_rdy_q     <= '0;
            ovf_q        <= '0;
        end else begin
            row_cnt_q    <= row_cnt_d;
            shard_done_q <= res_if.out_valid & res_if.out_ready & res_if.out_last;
            for (int p = 0; p < NUM_PE; p++) begin
                pe_rdy_q[p] <= (fcount_d[p] <= RDY_MAX);
                ovf_q[p]    <= ovf_q[p] | (pe_if.pe_row_en[p] & full[p]);
            end
            if (advance) begin
                for (int i = 1; i < W; i++) node_q[i] <= add_row(kid[2*i], kid[2*i+1]);
                vld_q[1]  <= pop;
                addr_q[1] <= row_cnt_q;
                for (int s = 2; s <= L; s++) begin
                    vld_q[s]  <= vld_q[s-1];
                    addr_q[s] <= addr_q[s-1];
                end
            end
        end
    end

    assign pe_if.pe_ready    = pe_rdy_q;
    assign res_if.out_valid  = vld_q[L];
    assign res_if.out_row    = node_q[1];
    assign res_if.out_addr   = addr_q[L];
    assign res_if.out_last   = vld_q[L] & (addr_q[L] == LAST_ADDR);
    assign res_if.shard_done = shard_done_q;
    assign res_if.ovf        = ovf_q;
endmodule

// File: tb/tb_mttkrp_output_merger.sv
// Scoreboard bench for the output merger: randomized PE streams, reference sums kept in a queue.
module tb_mttkrp_output_merger;
    import mttkrp_pkg::*;

    localparam int NPE   = 4;
    localparam int NROWS = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        row_t          row;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;

    merger_in_if  #(.NUM_PE(NPE))                       pin ();
    merger_out_if #(.NUM_PE(NPE), .ROW_ADDR_WIDTH(AW))  pout ();

    mttkrp_output_merger #(
        .NUM_PE(NPE), .NUM_ROWS(NROWS), .ROW_ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pe_if  (pin),
        .res_if (pout)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int first_vld = -1;
    int first_drv = -1;
    int pe3_cyc = -1;
    int start_dly [NPE];
    int gap_pct = 0;
    int stall_cnt = 0;
    bit rand_rdy = 0;
    bit bp_arm = 0;
    bit saw_low0 = 0;
    bit saw_all_low = 0;
    int model_addr = 0;

    row_t pend [NPE][$];
    exp_t exp_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string nm, string why);
        n_cmp++;
        n_err++;
        $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
    endfunction

    function automatic int pend_total();
        int t = 0;
        for (int p = 0; p < NPE; p++) t += pend[p].size();
        return t;
    endfunction

    // Reference: each merged row is the plain sum of the PE rows, reduced mod 2^32.
    task automatic sched(input int nrows, input int pat);
        for (int k = 0; k < nrows; k++) begin
            longint unsigned acc [RANK];
            exp_t e;
            for (int j = 0; j < RANK; j++) acc[j] = 0;
            for (int p = 0; p < NPE; p++) begin
                row_t r;
                for (int j = 0; j < RANK; j++) begin
                    case (pat)
                        0:       r[j] = 32'(100*k + 10*p + j);
                        1:       r[j] = 32'hC000_0000;
                        default: r[j] = $urandom();
                    endcase
                    acc[j] += longint'(r[j]);
                end
                pend[p].push_back(r);
            end
            for (int j = 0; j < RANK; j++) e.row[j] = 32'(acc[j] % 64'h1_0000_0000);
            e.addr = AW'(model_addr);
            e.last = (model_addr == NROWS - 1);
            exp_q.push_back(e);
            model_addr = (model_addr + 1) % NROWS;
        end
    endtask

    task automatic step();
        logic [NPE-1:0] en;
        @(posedge clk);
        #1;
        en = '0;
        for (int p = 0; p < NPE; p++) begin
            if (start_dly[p] > 0) begin
                start_dly[p]--;
            end else if (pend[p].size() > 0 && pin.pe_ready[p] && rst &&
                         $urandom_range(0, 99) >= gap_pct) begin
                pin.pe_row[p] = pend[p].pop_front();
                en[p] = 1'b1;
                if (first_drv < 0) first_drv = cyc;
                if (p == NPE - 1 && pe3_cyc < 0) pe3_cyc = cyc;
            end
        end
        pin.pe_row_en = en;
        if (bp_arm && first_vld >= 0) begin
            stall_cnt = 5;
            bp_arm = 0;
        end
        if (stall_cnt > 0) begin
            pout.out_ready = 1'b0;
            stall_cnt--;
        end else begin
            pout.out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rst && !pin.pe_ready[0]) saw_low0 = 1;
        if (rst && pin.pe_ready == '0) saw_all_low = 1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || pend_total() != 0) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) fail("drain_timeout", "rows still outstanding");
        repeat (4) step();
    endtask

    // Monitor: pops the scoreboard on each handshake, checks hold-under-stall and shard_done timing.
    initial begin
        logic          r_e;
        logic          stall_prev = 0;
        logic          exp_done = 0;
        row_t          prow;
        logic [AW-1:0] paddr;
        exp_t          e;
        forever begin
            @(posedge clk);
            r_e = rst;
            @(negedge clk);
            if (!r_e) begin
                chk("reset_ctl", {pout.out_valid, pout.out_last, pout.shard_done, pout.out_addr, pin.pe_ready}, '0);
                chk("reset_row", pout.out_row, '0);
                stall_prev = 0;
                exp_done = 0;
            end else if (rst) begin
                chk("shard_done", pout.shard_done, exp_done);
                if (pout.shard_done) done_cnt++;
                if (stall_prev) begin
                    chk("hold_addr", pout.out_addr, paddr);
                    chk("hold_row", pout.out_row, prow);
                end
                exp_done = 0;
                if (pout.out_valid && first_vld < 0) first_vld = cyc;
                if (pout.out_valid && pout.out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        fail("extra_beat", "output beat with empty scoreboard");
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_addr", pout.out_addr, e.addr);
                        chk("out_row", pout.out_row, e.row);
                        chk("out_last", pout.out_last, e.last);
                        exp_done = e.last;
                    end
                end
                stall_prev = pout.out_valid & ~pout.out_ready;
                prow = pout.out_row;
                paddr = pout.out_addr;
            end else begin
                stall_prev = 0;
                exp_done = 0;
            end
        end
    end

    initial begin
        int base;
        int n;
        rst = 1'b0;
        pin.pe_row_en = '0;
        pin.pe_row = '0;
        pout.out_ready = 1'b0;
        for (int p = 0; p < NPE; p++) start_dly[p] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        pout.out_ready = 1'b1;

        // Aligned drain with the closed-form data pattern.
        first_vld = -1; first_drv = -1;
        sched(NROWS, 0);
        wait_drain();
        chk("first_latency", 512'(first_vld), 512'(first_drv + 3));
        chk("ovf_basic", pout.ovf, '0);

        // PE3 starts late: merging waits for its first row, others throttle.
        first_vld = -1; pe3_cyc = -1; saw_low0 = 0;
        start_dly[NPE-1] = 3;
        sched(NROWS, 0);
        wait_drain();
        chk("skew_latency", 512'(first_vld), 512'(pe3_cyc + 3));
        chk("skew_ready_drop", saw_low0, 1'b1);
        chk("ovf_skew", pout.ovf, '0);

        // Five-cycle output stall mid-stream.
        first_vld = -1; saw_all_low = 0; bp_arm = 1;
        sched(NROWS, 2);
        wait_drain();
        chk("bp_all_ready_low", saw_all_low, 1'b1);
        chk("bp_ready_recover", pin.pe_ready, {NPE{1'b1}});

        // Element sums that overflow 32 bits.
        sched(NROWS, 1);
        wait_drain();
        chk("ovf_wrap", pout.ovf, '0);

        // Reset after three beats, then a fresh drain from address 0.
        sched(NROWS, 2);
        base = hs_cnt;
        n = 0;
        while (hs_cnt < base + 3 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) fail("reset_wait_timeout", "three beats never seen");
        @(posedge clk);
        #1;
        rst = 1'b0;
        pin.pe_row_en = '0;
        pout.out_ready = 1'b1;
        for (int p = 0; p < NPE; p++) pend[p].delete();
        exp_q.delete();
        model_addr = 0;
        @(posedge clk);
        #1 rst = 1'b1;
        sched(NROWS, 0);
        wait_drain();
        chk("ovf_reset", pout.ovf, '0);

        // Two shards back to back.
        base = done_cnt;
        sched(2*NROWS, 0);
        wait_drain();
        chk("b2b_done_pulses", 512'(done_cnt - base), 512'(2));

        // Random gaps, start skews and downstream readiness.
        rand_rdy = 1; gap_pct = 30;
        for (int p = 0; p < NPE; p++) start_dly[p] = $urandom_range(0, 5);
        base = done_cnt;
        sched(2*NROWS, 2);
        wait_drain();
        chk("rand_done_pulses", 512'(done_cnt - base), 512'(2));
        chk("ovf_rand", pout.ovf, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
